// File: rtl/milano_pkg.sv
`default_nettype none
// ============================================================================
// milano_pkg
// Shared constants and fetch-entry type for the milano core front end.
// Rev 1.0 - initial release
// ============================================================================
package milano_pkg;

    localparam logic [31:0] IF_BOOT_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
// if_fetch_fifo
// Synchronous FIFO of fetch entries with push/pop/flush and occupancy count.
// Rev 1.0 - initial release
// ============================================================================
module if_fetch_fifo
    import milano_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage
// Instruction fetch: PC generation, req/gnt/rvalid port, prefetch FIFO, IF/ID
// register. Optional macro IF_MISALIGN_EXC_EN adds misaligned-target trapping.
// Rev 1.0 - initial release
// ============================================================================
module if_stage
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = IF_BOOT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
`ifdef IF_MISALIGN_EXC_EN
    output logic        instr_misalign_o,
`endif
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_addr_id_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_rdata_q, id_rdata_d;
    logic [31:0]   id_addr_q, id_addr_d;

    logic          fetch_blocked, granted, rsp_keep, load_id, bypass;
    logic          data_push, data_pop, data_full, data_empty;
    logic          pcq_full, pcq_empty;
    logic [CW-1:0] data_count, pcq_count;
    fetch_entry_t  data_head, pcq_head, rsp_entry, pcq_entry;

`ifdef IF_MISALIGN_EXC_EN
    logic misalign_q, misalign_d;

    assign misalign_d       = jump_i ? (jump_addr_i[1:0] != 2'b00) : misalign_q;
    assign fetch_blocked    = misalign_q;
    assign instr_misalign_o = misalign_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign fetch_blocked = 1'b0;
`endif

    assign instr_req_o  = !rst_i && !fetch_blocked &&
                          (({1'b0, outstanding_q} + {1'b0, data_count}) < (CW+1)'(FIFO_DEPTH));
    assign instr_addr_o = fetch_pc_q;
    assign granted      = instr_req_o && instr_gnt_i;

    // A response is kept only if no stale fetch is still draining and no redirect is in flight.
    assign rsp_keep  = instr_rvalid_i && (discard_q == '0) && !jump_i;
    assign load_id   = !stall_i || !id_valid_q;
    assign data_pop  = load_id && !data_empty && !jump_i;
    assign bypass    = load_id && data_empty && rsp_keep;
    assign data_push = rsp_keep && !bypass;

    always_comb begin
        rsp_entry       = pcq_head;
        rsp_entry.rdata = instr_rdata_i;
        pcq_entry       = '{rdata: 32'h0, addr: fetch_pc_q};
    end

    if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (jump_i),
        .push_i      (data_push),
        .push_data_i (rsp_entry),
        .pop_i       (data_pop),
        .head_o      (data_head),
        .count_o     (data_count),
        .full_o      (data_full),
        .empty_o     (data_empty)
    );

    if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (jump_i),
        .push_i      (granted && !jump_i),
        .push_data_i (pcq_entry),
        .pop_i       (rsp_keep),
        .head_o      (pcq_head),
        .count_o     (pcq_count),
        .full_o      (pcq_full),
        .empty_o     (pcq_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(granted) - CW'(instr_rvalid_i);
        discard_d     = discard_q;
        id_valid_d    = id_valid_q;
        id_rdata_d    = id_rdata_q;
        id_addr_d     = id_addr_q;
        if (jump_i) begin
            fetch_pc_d = jump_addr_i & ~32'h3;
            discard_d  = outstanding_d;
            id_valid_d = 1'b0;
        end else begin
            if (granted) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (instr_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (load_id) begin
                if (!data_empty) begin
                    id_valid_d = 1'b1;
                    id_rdata_d = data_head.rdata;
                    id_addr_d  = data_head.addr;
                end else if (rsp_keep) begin
                    id_valid_d = 1'b1;
                    id_rdata_d = rsp_entry.rdata;
                    id_addr_d  = rsp_entry.addr;
                end else begin
                    id_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            id_valid_q    <= 1'b0;
            id_rdata_q    <= INSTR_NOP;
            id_addr_q     <= BOOT_ADDR;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            id_valid_q    <= id_valid_d;
            id_rdata_q    <= id_rdata_d;
            id_addr_q     <= id_addr_d;
        end
    end

    assign instr_valid_id_o = id_valid_q;
    assign instr_rdata_id_o = id_rdata_q;
    assign instr_addr_id_o  = id_addr_q;

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(data_push && data_full && !data_pop));
    a_pcq_sane: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_keep && pcq_empty) && !(granted && !jump_i && pcq_full));
    a_outstanding_balance: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_q == pcq_count + discard_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage
// Self-checking bench: in-order memory model with random latency/grants and an
// expected-PC-stream reference for the ID interface.
// Rev 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          FD   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_addr_id_o;
`ifdef IF_MISALIGN_EXC_EN
    logic        instr_misalign_o;
`endif

    if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(FD)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .stall_i          (stall_i),
        .jump_i           (jump_i),
        .jump_addr_i      (jump_addr_i),
`ifdef IF_MISALIGN_EXC_EN
        .instr_misalign_o (instr_misalign_o),
`endif
        .instr_valid_id_o (instr_valid_id_o),
        .instr_rdata_id_o (instr_rdata_id_o),
        .instr_addr_id_o  (instr_addr_id_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          consumed = 0;
    int          gnt_mode = 1;   // 0 random, 1 always, 2 never
    int          lat_max = 0;
    logic [31:0] exp_pc = BOOT;
    logic [31:0] q_addr[$];
    int          q_ready[$];

    logic        have_prev = 1'b0;
    logic        p_rst, p_stall, p_jump, p_req, p_gnt, p_valid;
    logic [31:0] p_jaddr, p_addr, p_rdata_id, p_addr_id;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, update model at posedge.
    task automatic step(input logic st, input logic jp, input logic [31:0] ja);
        logic [31:0] exp_addr;
        logic        rv;
        stall_i     = st;
        jump_i      = jp;
        jump_addr_i = ja;
        case (gnt_mode)
            1:       instr_gnt_i = 1'b1;
            2:       instr_gnt_i = 1'b0;
            default: instr_gnt_i = ($urandom_range(0, 3) != 0);
        endcase
        rv = !rst_i && (q_addr.size() > 0) && (q_ready[0] <= cyc);
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? memf(q_addr[0]) : $urandom;
        #1;
        if (rst_i) chk("req_in_reset", instr_req_o, 1'b0);
        if (have_prev && p_rst) begin
            chk("rst_addr", instr_addr_o, BOOT);
            chk("rst_valid", instr_valid_id_o, 1'b0);
            chk("rst_rdata_id", instr_rdata_id_o, NOP);
            chk("rst_addr_id", instr_addr_id_o, BOOT);
`ifdef IF_MISALIGN_EXC_EN
            chk("rst_misalign", instr_misalign_o, 1'b0);
`endif
        end else if (have_prev) begin
            if (p_jump)              exp_addr = {p_jaddr[31:2], 2'b00};
            else if (p_req && p_gnt) exp_addr = p_addr + 32'd4;
            else                     exp_addr = p_addr;
            chk("fetch_addr", instr_addr_o, exp_addr);
            if (p_jump) chk("valid_after_jump", instr_valid_id_o, 1'b0);
            if (p_stall && p_valid && !p_jump) begin
                chk("stall_hold_valid", instr_valid_id_o, 1'b1);
                chk("stall_hold_rdata", instr_rdata_id_o, p_rdata_id);
                chk("stall_hold_addr", instr_addr_id_o, p_addr_id);
            end
        end
        if (!rst_i && instr_valid_id_o === 1'b1) begin
            chk("id_addr", instr_addr_id_o, exp_pc);
            chk("id_rdata", instr_rdata_id_o, memf(instr_addr_id_o));
        end
`ifdef IF_MISALIGN_EXC_EN
        if (instr_misalign_o === 1'b1) chk("misalign_no_valid", instr_valid_id_o, 1'b0);
`endif
        chk("outstanding_cap", (q_addr.size() <= FD), 1'b1);
        p_rst = rst_i;  p_stall = st;  p_jump = jp;  p_jaddr = ja;
        p_req = instr_req_o;  p_gnt = instr_gnt_i;  p_addr = instr_addr_o;
        p_valid = instr_valid_id_o;  p_rdata_id = instr_rdata_id_o;  p_addr_id = instr_addr_id_o;
        have_prev = 1'b1;
        @(posedge clk_i);
        if (p_rst) begin
            q_addr.delete();
            q_ready.delete();
            exp_pc = BOOT;
        end else begin
            if (p_valid && !st) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (jp) exp_pc = {ja[31:2], 2'b00};
            if (rv) begin
                void'(q_addr.pop_front());
                void'(q_ready.pop_front());
            end
            if (p_req && p_gnt) begin
                q_addr.push_back(p_addr);
                q_ready.push_back(cyc + 1 + $urandom_range(0, lat_max));
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run_until_valid(input logic [31:0] exp_a);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid_id_o === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("reach_valid", found, 1'b1);
        if (found) chk("first_after_jump", instr_addr_id_o, exp_a);
    endtask

    initial begin
        logic [31:0] held;
        logic        hit;
        logic [31:0] ja;
        rst_i = 1'b1;  stall_i = 1'b0;  jump_i = 1'b0;  jump_addr_i = '0;
        instr_gnt_i = 1'b0;  instr_rvalid_i = 1'b0;  instr_rdata_i = '0;
        @(negedge clk_i);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Streaming with grant every cycle and 1-cycle response latency
        rst_i = 1'b0;  gnt_mode = 1;  lat_max = 0;
        #1;
        chk("first_req", instr_req_o, 1'b1);
        chk("first_addr", instr_addr_o, BOOT);
        step(1'b0, 1'b0, 32'h0);
        chk("lat_c1_valid", instr_valid_id_o, 1'b0);
        chk("lat_c1_addr", instr_addr_o, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("lat_c2_valid", instr_valid_id_o, 1'b1);
        chk("lat_c2_addr_id", instr_addr_id_o, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Long stall: buffering saturates and requests stop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
        chk("req_low_when_full", instr_req_o, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

        // Redirect with fetches in flight
        lat_max = 2;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0100);
        run_until_valid(32'h0000_0100);

        // Redirect coinciding with a response and a stall
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (q_addr.size() > 0 && q_ready[0] <= cyc) hit = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("found_rvalid_slot", hit, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0300);
        run_until_valid(32'h0000_0300);

        // Grant withheld
        gnt_mode = 2;
        held = instr_addr_o;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        chk("addr_stable_no_gnt", instr_addr_o, held);
        gnt_mode = 1;
        step(1'b0, 1'b0, 32'h0);
        chk("addr_adv_on_gnt", instr_addr_o, held + 32'd4);

        // Random traffic
        gnt_mode = 0;  lat_max = 2;
        for (int i = 0; i < 800; i++) begin
            ja = $urandom;
`ifdef IF_MISALIGN_EXC_EN
            ja = ja & ~32'h3;
`endif
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), ja);
        end

        // Reset in the middle of traffic
        rst_i = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 100; i++) step(($urandom_range(0, 3) == 0), 1'b0, 32'h0);

`ifdef IF_MISALIGN_EXC_EN
        step(1'b0, 1'b1, 32'h0000_0102);
        chk("misalign_set", instr_misalign_o, 1'b1);
        chk("misalign_req", instr_req_o, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        chk("misalign_hold", instr_misalign_o, 1'b1);
        chk("misalign_req_hold", instr_req_o, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0200);
        chk("misalign_clear", instr_misalign_o, 1'b0);
        run_until_valid(32'h0000_0200);
`endif

        chk("stream_progress", (consumed >= 100), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
